bomberman_control: RTL
======================

BOMBERMAN_CONTROL -- requirements
Module: bomberman_control

Interface
REQ-001 SHALL have port clock, input, 1, system clock; all flops rise on its posedge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, level; leaves the idle or game-over state.
REQ-004 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-005 SHALL have ports finished, all_tiles_drawn, game_over, inputs, 1 each, from the datapath.
REQ-006 SHALL have ports p1_left, p1_right, p1_up, p1_down, p1_fire, inputs, 1 each, raw player-1 keys; p2_* identical for player 2.
REQ-007 SHALL have port memory_select, output, 2: 0=tile, 1=player-1 sprite, 2=player-2 sprite, 3 unused.
REQ-008 SHALL have ports copy_enable, tc_enable, player_reset, stage_reset, outputs, 1 each, one-cycle pulses.
REQ-009 SHALL have ports draw_t, draw_p1, draw_p2, outputs, 1 each, levels, at most one high.
REQ-010 SHALL have ports p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb (and p2_*), outputs, 1 each; xdir 1=right, ydir 1=down.

Function
REQ-011 SHALL implement states S_IDLE, S_INIT, S_T_LOAD, S_T_DRAW, S_T_NEXT, S_P1_LOAD, S_P1_DRAW, S_P2_LOAD, S_P2_DRAW, S_WAIT, S_MOVE, S_OVER.
REQ-012 S_IDLE: all outputs 0; start=1 -> S_INIT.
REQ-013 S_INIT (one cycle): player_reset=1, stage_reset=1 -> S_T_LOAD.
REQ-014 S_T_LOAD (one cycle): draw_t=1, memory_select=0, copy_enable=1 -> S_T_DRAW.
REQ-015 S_T_DRAW: draw_t=1, memory_select=0; finished=1 -> tc_enable=1 same cycle, go to S_T_NEXT.
REQ-016 S_T_NEXT (one cycle, samples post-increment all_tiles_drawn): 1 -> S_P1_LOAD, 0 -> S_T_LOAD.
REQ-017 S_P1_LOAD/S_P1_DRAW: as REQ-014/015, draw_p1=1, memory_select=1, no tc_enable; finished -> S_P2_LOAD.
REQ-018 S_P2_LOAD/S_P2_DRAW: draw_p2=1, memory_select=2; finished -> S_WAIT.
REQ-019 S_WAIT: outputs idle; game_over=1 -> S_OVER (priority); else frame_tick=1 -> S_MOVE.
REQ-020 S_MOVE (one cycle): drive movement pulses (REQ-022..024), clear key latches -> S_T_LOAD.
REQ-021 S_OVER: outputs idle; start=1 -> S_INIT.
REQ-022 Each key SHALL be latched sticky (set while key high, any state except S_IDLE) and cleared on exit of S_MOVE; a key high during S_MOVE sets the latch for the next frame.
REQ-023 In S_MOVE: xmov=1 iff exactly one of left/right latched, xdir=right; ymov=1 iff exactly one of up/down latched, ydir=down; opposite pair -> no move; dir=0 when mov=0.
REQ-024 In S_MOVE: bomb=1 iff fire latched; all movement/bomb outputs 0 outside S_MOVE.
REQ-025 finished while not in a *_DRAW state SHALL be ignored; frame_tick outside S_WAIT SHALL be ignored (no queuing).
REQ-026 Outputs SHALL be decoded from registered state only (Moore), no input-to-output combinational path except tc_enable (REQ-015).

Reset
REQ-027 reset=1 at any clock edge SHALL force S_IDLE, clear all key latches, and drive every output 0 on the following cycle, including mid-draw.
REQ-028 player_reset/stage_reset SHALL NOT assert during reset; only via S_INIT.

Structure
REQ-029 State encoding and memory_select constants (SEL_TILE=0, SEL_P1=1, SEL_P2=2) SHALL live in a shared bomberman package/header.
REQ-030 Key latching and REQ-023/024 decode SHALL be one sub-module, bomberman_input_latch, instantiated once per player.

Verification
REQ-031 Reset, start=1 one cycle -> player_reset and stage_reset high exactly one cycle, then copy_enable pulse with draw_t=1, memory_select=0.
REQ-032 Datapath model asserting finished 3 cycles after each copy_enable, all_tiles_drawn after 121st tc_enable -> exactly 121 tc_enable, then one P1 and one P2 draw, then S_WAIT.
REQ-033 p1_right pulsed 1 cycle in S_T_DRAW, then frame_tick -> single cycle p1_xmov=1, p1_xdir=1; next frame no movement.
REQ-034 p2_left and p2_right both held, p2_up held, p2_fire pulsed -> p2_xmov=0, p2_ymov=1, p2_ydir=0, p2_bomb=1.
REQ-035 game_over=1 and frame_tick=1 same cycle in S_WAIT -> S_OVER, no movement pulse; start -> S_INIT.
REQ-036 reset asserted during S_P1_DRAW -> next cycle all outputs 0, state S_IDLE, later finished ignored.

Source files
------------

// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman game controller: FSM state encoding,
// memory-select codes and packed key/movement bundles.
package bomberman_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_T_LOAD  = 4'd2,
        S_T_DRAW  = 4'd3,
        S_T_NEXT  = 4'd4,
        S_P1_LOAD = 4'd5,
        S_P1_DRAW = 4'd6,
        S_P2_LOAD = 4'd7,
        S_P2_DRAW = 4'd8,
        S_WAIT    = 4'd9,
        S_MOVE    = 4'd10,
        S_OVER    = 4'd11
    } state_t;

    localparam logic [1:0] SEL_TILE = 2'd0;
    localparam logic [1:0] SEL_P1   = 2'd1;
    localparam logic [1:0] SEL_P2   = 2'd2;

    // Raw keys of one player, packed in this fixed order.
    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
        logic fire;
    } keys_t;

    // Movement request of one player for the current frame.
    typedef struct packed {
        logic xmov;
        logic xdir;
        logic ymov;
        logic ydir;
        logic bomb;
    } move_t;

    // Opposing keys cancel: a move happens only when exactly one is held.
    function automatic logic exactly_one(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/bomberman_input_latch.sv
// Per-player sticky key capture and movement decode. Keys are collected
// across a whole frame so short presses between move phases are not lost.
module bomberman_input_latch
    import bomberman_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  enable,
    input  logic  move_phase,
    input  keys_t keys,
    output move_t move
);

    keys_t held;

    // Sticky capture; the move cycle restarts collection with the keys present then.
    always_ff @(posedge clock) begin
        if (reset) begin
            held <= '0;
        end else if (move_phase) begin
            held <= keys;
        end else if (enable) begin
            held <= held | keys;
        end
    end

    // Movement is only presented during the move cycle; direction is zero when not moving.
    always_comb begin
        move = '0;
        if (move_phase) begin
            move.xmov = exactly_one(held.left, held.right);
            move.xdir = move.xmov & held.right;
            move.ymov = exactly_one(held.up, held.down);
            move.ydir = move.ymov & held.down;
            move.bomb = held.fire;
        end
    end

endmodule

// File: rtl/bomberman_control.sv
// Bomberman frame controller: sequences tile, player-1 and player-2 drawing,
// waits for the frame tick, then issues one cycle of player movement.
module bomberman_control
    import bomberman_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       finished,
    input  logic       all_tiles_drawn,
    input  logic       game_over,
    input  logic       p1_left,
    input  logic       p1_right,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p1_fire,
    input  logic       p2_left,
    input  logic       p2_right,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       p2_fire,
    output logic [1:0] memory_select,
    output logic       copy_enable,
    output logic       tc_enable,
    output logic       player_reset,
    output logic       stage_reset,
    output logic       draw_t,
    output logic       draw_p1,
    output logic       draw_p2,
    output logic       p1_xmov,
    output logic       p1_xdir,
    output logic       p1_ymov,
    output logic       p1_ydir,
    output logic       p1_bomb,
    output logic       p2_xmov,
    output logic       p2_xdir,
    output logic       p2_ymov,
    output logic       p2_ydir,
    output logic       p2_bomb
);

    state_t state;
    state_t state_next;
    keys_t  p1_keys;
    keys_t  p2_keys;
    move_t  p1_move;
    move_t  p2_move;
    logic   keys_live;
    logic   move_phase;

    assign p1_keys    = {p1_left, p1_right, p1_up, p1_down, p1_fire};
    assign p2_keys    = {p2_left, p2_right, p2_up, p2_down, p2_fire};
    assign keys_live  = (state != S_IDLE);
    assign move_phase = (state == S_MOVE);

    assign {p1_xmov, p1_xdir, p1_ymov, p1_ydir, p1_bomb} = p1_move;
    assign {p2_xmov, p2_xdir, p2_ymov, p2_ydir, p2_bomb} = p2_move;

    // State register; reset always returns to idle, even mid-draw.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; tc_enable alone follows finished in the same cycle.
    always_comb begin
        state_next    = state;
        memory_select = SEL_TILE;
        copy_enable   = 1'b0;
        tc_enable     = 1'b0;
        player_reset  = 1'b0;
        stage_reset   = 1'b0;
        draw_t        = 1'b0;
        draw_p1       = 1'b0;
        draw_p2       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_INIT;
            end
            S_INIT: begin
                player_reset = 1'b1;
                stage_reset  = 1'b1;
                state_next   = S_T_LOAD;
            end
            S_T_LOAD: begin
                draw_t      = 1'b1;
                copy_enable = 1'b1;
                state_next  = S_T_DRAW;
            end
            S_T_DRAW: begin
                draw_t = 1'b1;
                if (finished) begin
                    tc_enable  = 1'b1;
                    state_next = S_T_NEXT;
                end
            end
            S_T_NEXT: begin
                // all_tiles_drawn here already reflects the tile just counted.
                state_next = all_tiles_drawn ? S_P1_LOAD : S_T_LOAD;
            end
            S_P1_LOAD: begin
                draw_p1       = 1'b1;
                memory_select = SEL_P1;
                copy_enable   = 1'b1;
                state_next    = S_P1_DRAW;
            end
            S_P1_DRAW: begin
                draw_p1       = 1'b1;
                memory_select = SEL_P1;
                if (finished) state_next = S_P2_LOAD;
            end
            S_P2_LOAD: begin
                draw_p2       = 1'b1;
                memory_select = SEL_P2;
                copy_enable   = 1'b1;
                state_next    = S_P2_DRAW;
            end
            S_P2_DRAW: begin
                draw_p2       = 1'b1;
                memory_select = SEL_P2;
                if (finished) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (game_over) begin
                    state_next = S_OVER;
                end else if (frame_tick) begin
                    state_next = S_MOVE;
                end
            end
            S_MOVE: begin
                state_next = S_T_LOAD;
            end
            S_OVER: begin
                if (start) state_next = S_INIT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    bomberman_input_latch u_p1_latch (
        .clock      (clock),
        .reset      (reset),
        .enable     (keys_live),
        .move_phase (move_phase),
        .keys       (p1_keys),
        .move       (p1_move)
    );

    bomberman_input_latch u_p2_latch (
        .clock      (clock),
        .reset      (reset),
        .enable     (keys_live),
        .move_phase (move_phase),
        .keys       (p2_keys),
        .move       (p2_move)
    );

endmodule
